// File: rtl/field_assembler.sv
// field_assembler
//   Builds RV32I instruction words from a stream of field tokens
//   (OPC, REG, IMM, TARGET, EOL) and queues {instruction, byte PC} in a
//   first-word fall-through FIFO of DEPTH entries.
//
// Ports
//   clk_in          single clock
//   rst_n_in        synchronous active-low reset
//   flush_in        synchronous restart: FIFO emptied, FSM to IDLE, pc to 0
//   fld_valid_in / fld_ready_out / fld_kind_in / fld_data_in
//                   field token handshake; kind 0=OPC 1=REG 2=IMM 3=TARGET 4=EOL
//   inst_valid_out / inst_ready_in / inst_out / inst_pc_out
//                   FIFO head (instruction word and its byte PC)
//   error_out       one-cycle pulse per errored line
//   error_code_out  last error: 1=bad token/opcode, 2=early EOL, 3=range
//   count_out       FIFO occupancy
//
// Build option
//   IMM_RANGE_CHECK_EN : when defined, immediates and branch/jump offsets are
//   range-checked before a push; an out-of-range line raises code 3 and is
//   dropped. When undefined, out-of-range values are silently truncated.
module field_assembler #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     flush_in,
  input  logic                     fld_valid_in,
  output logic                     fld_ready_out,
  input  logic [2:0]               fld_kind_in,
  input  logic [31:0]              fld_data_in,
  output logic                     inst_valid_out,
  input  logic                     inst_ready_in,
  output logic [31:0]              inst_out,
  output logic [PC_WIDTH+1:0]      inst_pc_out,
  output logic                     error_out,
  output logic [1:0]               error_code_out,
  output logic [$clog2(DEPTH):0]   count_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = PC_WIDTH + 2;
  localparam int EW = 32 + PW;

  localparam logic [2:0] K_OPC = 3'd0, K_REG = 3'd1, K_IMM = 3'd2,
                         K_TGT = 3'd3, K_EOL = 3'd4;

  localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OPIMM = 7'b0010011,
                         OPC_LOAD   = 7'b0000011, OPC_JALR  = 7'b1100111,
                         OPC_STORE  = 7'b0100011, OPC_BRANCH = 7'b1100011,
                         OPC_LUI    = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    IDLE, READ_RD, READ_RS1, READ_RS2, READ_IMM, READ_LABEL, WAIT_EOL, ENCODE, DRAIN
  } state_t;

  function automatic logic known_opc(input logic [6:0] op);
    return op inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE,
                      OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL};
  endfunction

  // Field order per opcode; cur==IDLE means "just latched the OPC token".
  function automatic state_t next_field(input state_t cur, input logic [6:0] op);
    case (cur)
      IDLE:     return (op == OPC_STORE) ? READ_RS2 : (op == OPC_BRANCH) ? READ_RS1 : READ_RD;
      READ_RD:  return (op == OPC_LUI || op == OPC_AUIPC) ? READ_IMM :
                       (op == OPC_JAL) ? READ_LABEL : READ_RS1;
      READ_RS1: return (op == OPC_OP || op == OPC_BRANCH) ? READ_RS2 : READ_IMM;
      READ_RS2: return (op == OPC_OP) ? WAIT_EOL : (op == OPC_STORE) ? READ_RS1 : READ_LABEL;
      default:  return WAIT_EOL;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [6:0]    opc_q, opc_d, f7_q, f7_d;
  logic [2:0]    f3_q, f3_d;
  logic [4:0]    rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]   imm_q, imm_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          enc_done_q, enc_done_d;
  logic [31:0]   enc_q, enc_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          accept, full, push, pop, kind_ok;
  logic [31:0]   encoded, label_off;
  logic [EW-1:0] head;

  assign fld_ready_out = (state_q != ENCODE);
  assign accept        = fld_valid_in && fld_ready_out;
  assign full          = (count_q == (AW+1)'(DEPTH));
  assign label_off     = 32'({fld_data_in[PC_WIDTH-1:0], 2'b00}) - 32'(pc_q);

  assign kind_ok = ((state_q inside {READ_RD, READ_RS1, READ_RS2}) && fld_kind_in == K_REG) ||
                   (state_q == READ_IMM   && fld_kind_in == K_IMM) ||
                   (state_q == READ_LABEL && fld_kind_in == K_TGT);

  always_comb begin
    case (opc_q)
      OPC_OP:              encoded = {f7_q, rs2_q, rs1_q, f3_q, rd_q, opc_q};
      OPC_OPIMM:           encoded = {imm_q[11:5] | f7_q, imm_q[4:0], rs1_q, f3_q, rd_q, opc_q};
      OPC_LOAD, OPC_JALR:  encoded = {imm_q[11:0], rs1_q, f3_q, rd_q, opc_q};
      OPC_STORE:           encoded = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], opc_q};
      OPC_BRANCH:          encoded = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                                      imm_q[4:1], imm_q[11], opc_q};
      OPC_LUI, OPC_AUIPC:  encoded = {imm_q[19:0], rd_q, opc_q};
      OPC_JAL:             encoded = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opc_q};
      default:             encoded = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic range_ok;
  always_comb begin
    range_ok = 1'b1;
    case (opc_q)
      OPC_OPIMM:
        if (f3_q == 3'b001 || f3_q == 3'b101) range_ok = (imm_q[31:5] == '0);
        else range_ok = (&imm_q[31:11]) || ~(|imm_q[31:11]);
      OPC_LOAD, OPC_JALR, OPC_STORE:
        range_ok = (&imm_q[31:11]) || ~(|imm_q[31:11]);
      OPC_LUI, OPC_AUIPC:
        range_ok = (imm_q[31:20] == '0);
      OPC_BRANCH:
        range_ok = ((&imm_q[31:12]) || ~(|imm_q[31:12])) && !imm_q[0];
      OPC_JAL:
        range_ok = ((&imm_q[31:20]) || ~(|imm_q[31:20])) && !imm_q[0];
      default: range_ok = 1'b1;
    endcase
  end
`else
  logic unused_imm_bits;
  assign unused_imm_bits = ^imm_q[31:21];
`endif

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    f3_d       = f3_q;
    f7_d       = f7_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    enc_done_d = enc_done_q;
    enc_d      = enc_q;
    err_d      = 1'b0;
    code_d     = code_q;
    push       = 1'b0;

    case (state_q)
      IDLE: if (accept) begin
        if (fld_kind_in == K_OPC && known_opc(fld_data_in[6:0])) begin
          opc_d   = fld_data_in[6:0];
          f3_d    = fld_data_in[9:7];
          f7_d    = fld_data_in[16:10];
          state_d = next_field(IDLE, fld_data_in[6:0]);
        end else if (fld_kind_in != K_EOL) begin
          err_d = 1'b1; code_d = 2'd1; state_d = DRAIN;
        end
      end
      READ_RD, READ_RS1, READ_RS2, READ_IMM, READ_LABEL: if (accept) begin
        if (kind_ok) begin
          case (state_q)
            READ_RD:    rd_d  = fld_data_in[4:0];
            READ_RS1:   rs1_d = fld_data_in[4:0];
            READ_RS2:   rs2_d = fld_data_in[4:0];
            READ_IMM:   imm_d = fld_data_in;
            default:    imm_d = label_off;  // labels are stored as pc-relative offsets
          endcase
          state_d = next_field(state_q, opc_q);
        end else if (fld_kind_in == K_EOL) begin
          err_d = 1'b1; code_d = 2'd2; state_d = IDLE;
        end else begin
          err_d = 1'b1; code_d = 2'd1; state_d = DRAIN;
        end
      end
      WAIT_EOL: if (accept) begin
        if (fld_kind_in == K_EOL) begin
          state_d = ENCODE; enc_done_d = 1'b0;
        end else begin
          err_d = 1'b1; code_d = 2'd1; state_d = DRAIN;
        end
      end
      // First cycle registers the encoded word (and range verdict); later
      // cycles push it once the FIFO has room.
      ENCODE: begin
        if (!enc_done_q) begin
`ifdef IMM_RANGE_CHECK_EN
          if (!range_ok) begin
            err_d = 1'b1; code_d = 2'd3; state_d = IDLE;
          end else
`endif
          begin
            enc_d = encoded; enc_done_d = 1'b1;
          end
        end else if (!full) begin
          push = 1'b1; pc_d = pc_q + PW'(4); enc_done_d = 1'b0; state_d = IDLE;
        end
      end
      DRAIN: if (accept && fld_kind_in == K_EOL) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush_in) begin
      state_d = IDLE; pc_d = '0; enc_done_d = 1'b0;
      err_d = 1'b0; code_d = code_q; push = 1'b0;
    end
  end

  // FIFO pointers; a full FIFO never sees push, so push/pop are independent.
  always_comb begin
    pop      = inst_ready_in && (count_q != '0) && !flush_in;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    if (flush_in) begin
      wr_ptr_d = '0; rd_ptr_d = '0; count_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;  opc_q <= '0; f3_q <= '0; f7_q <= '0;
      rd_q <= '0; rs1_q <= '0; rs2_q <= '0; imm_q <= '0; pc_q <= '0;
      enc_done_q <= 1'b0; enc_q <= '0; err_q <= 1'b0; code_q <= '0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
    end else begin
      state_q <= state_d; opc_q <= opc_d; f3_q <= f3_d; f7_q <= f7_d;
      rd_q <= rd_d; rs1_q <= rs1_d; rs2_q <= rs2_d; imm_q <= imm_d; pc_q <= pc_d;
      enc_done_q <= enc_done_d; enc_q <= enc_d; err_q <= err_d; code_q <= code_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_n_in && push) mem_q[wr_ptr_q] <= {enc_q, pc_q};
  end

  // Head is forced to zero when empty so reset/flush present clean outputs.
  assign head           = mem_q[rd_ptr_q];
  assign inst_valid_out = (count_q != '0);
  assign inst_out       = inst_valid_out ? head[EW-1:PW] : '0;
  assign inst_pc_out    = inst_valid_out ? head[PW-1:0]  : '0;
  assign error_out      = err_q;
  assign error_code_out = code_q;
  assign count_out      = count_q;
endmodule
